// File: rtl/stack_register_file_pkg.sv
// Shared definitions for the stack register file.
//   calc_aw       : index width for a given register count (never below 1 bit)
//   R0..MA        : conventional register indices (SP is the stack pointer)
//   sp_op_e       : stack-pointer operation selected for the current cycle
//   decode_sp_op  : resolves load/inc/dec requests into one sp_op_e
package stack_register_file_pkg;

    localparam int unsigned R0 = 32'd0;
    localparam int unsigned R1 = 32'd1;
    localparam int unsigned R2 = 32'd2;
    localparam int unsigned R3 = 32'd3;
    localparam int unsigned R4 = 32'd4;
    localparam int unsigned SP = 32'd5;
    localparam int unsigned MD = 32'd6;
    localparam int unsigned MA = 32'd7;

    typedef enum logic [1:0] {
        SP_OP_HOLD = 2'd0,
        SP_OP_LOAD = 2'd1,
        SP_OP_INC  = 2'd2,
        SP_OP_DEC  = 2'd3
    } sp_op_e;

    function automatic int calc_aw(input int n);
        int w;
        w = $clog2(n);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    // Load beats inc/dec; inc and dec together cancel out into a hold.
    function automatic sp_op_e decode_sp_op(input logic load, input logic inc, input logic dec);
        sp_op_e op;
        if (load) begin
            op = SP_OP_LOAD;
        end else if (inc && !dec) begin
            op = SP_OP_INC;
        end else if (dec && !inc) begin
            op = SP_OP_DEC;
        end else begin
            op = SP_OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_register_file_sp_counter.sv
// Stack-pointer register with load / increment / decrement and sticky
// wrap flags.
//   clk, clear   : clock and synchronous active-high clear
//   load         : load_data written into SP (wins over inc/dec)
//   load_data    : value for load
//   inc, dec     : pop / push requests; both together hold
//   sp           : registered SP value
//   overflow     : sticky, set when inc wraps all-ones -> 0
//   underflow    : sticky, set when dec wraps 0 -> all-ones
module stack_register_file_sp_counter
    import stack_register_file_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  SP_RESET = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              inc,
    input  logic              dec,
    output logic [DATA_W-1:0] sp,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ALL_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1'b1);

    sp_op_e            op_s;
    logic [DATA_W-1:0] sp_r;
    logic [DATA_W-1:0] sp_nxt_s;
    logic              ovf_r;
    logic              ovf_nxt_s;
    logic              udf_r;
    logic              udf_nxt_s;

    // Next SP value and flag updates for the selected operation.
    always_comb begin
        op_s      = decode_sp_op(load, inc, dec);
        sp_nxt_s  = sp_r;
        ovf_nxt_s = ovf_r;
        udf_nxt_s = udf_r;
        case (op_s)
            SP_OP_LOAD: begin
                sp_nxt_s = load_data;
            end
            SP_OP_INC: begin
                sp_nxt_s = sp_r + ONE;
                if (sp_r == ALL_ONES) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    ovf_nxt_s = ovf_r;
                end
            end
            SP_OP_DEC: begin
                sp_nxt_s = sp_r - ONE;
                if (sp_r == ALL_ZERO) begin
                    udf_nxt_s = 1'b1;
                end else begin
                    udf_nxt_s = udf_r;
                end
            end
            SP_OP_HOLD: begin
                sp_nxt_s = sp_r;
            end
            default: begin
                sp_nxt_s = sp_r;
            end
        endcase
    end

    // SP and flag registers; clear overrides every request.
    always_ff @(posedge clk) begin
        if (clear) begin
            sp_r  <= SP_RESET;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            sp_r  <= sp_nxt_s;
            ovf_r <= ovf_nxt_s;
            udf_r <= udf_nxt_s;
        end
    end

    assign sp        = sp_r;
    assign overflow  = ovf_r;
    assign underflow = udf_r;

endmodule

// File: rtl/stack_register_file.sv
// General-purpose register file with one write port, two combinational read
// ports and a dedicated stack-pointer register at index SP_IDX.
//   clk, clear            : clock and synchronous active-high clear
//   dataIn / writeSelect / writeEnable : write port (1-cycle latency)
//   readSelectA/B, dataOutA/B          : combinational read ports
//   spInc / spDec         : pop (SP+1) / push (SP-1)
//   spOut                 : registered SP value
//   spOverflow/Underflow  : sticky SP wrap flags, cleared only by clear
// Out-of-range write indices are ignored and out-of-range reads return 0.
// With BYPASS=1 a same-cycle write to the selected index is forwarded;
// SP inc/dec results are never forwarded.
module stack_register_file
    import stack_register_file_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 8,
    parameter int                SP_IDX   = 5,
    parameter logic [DATA_W-1:0] SP_RESET = {DATA_W{1'b1}},
    parameter bit                BYPASS   = 1'b1,
    localparam int               AW       = calc_aw(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [AW-1:0]     writeSelect,
    input  logic              writeEnable,
    input  logic [AW-1:0]     readSelectA,
    input  logic [AW-1:0]     readSelectB,
    output logic [DATA_W-1:0] dataOutA,
    output logic [DATA_W-1:0] dataOutB,
    input  logic              spInc,
    input  logic              spDec,
    output logic [DATA_W-1:0] spOut,
    output logic              spOverflow,
    output logic              spUnderflow
);

    // The array skips the SP slot; indices above SP_IDX shift down by one.
    localparam int                PHYS_N     = NUM_REGS - 1;
    localparam logic [AW:0]       NUM_REGS_W = NUM_REGS[AW:0];
    localparam logic [AW-1:0]     SP_IDX_W   = SP_IDX[AW-1:0];
    localparam logic [DATA_W-1:0] ALL_ZERO   = {DATA_W{1'b0}};

    function automatic logic [AW-1:0] to_phys(input logic [AW-1:0] idx);
        logic [AW-1:0] p;
        if (idx > SP_IDX_W) begin
            p = idx - AW'(1'b1);
        end else begin
            p = idx;
        end
        return p;
    endfunction

    logic [DATA_W-1:0] regs_r [PHYS_N];
    logic [DATA_W-1:0] sp_value_s;
    logic              wr_in_range_s;
    logic              wr_is_sp_s;
    logic              wr_array_s;
    logic              sp_load_s;
    logic [AW-1:0]     wr_phys_s;
    logic [AW-1:0]     rd_sel_s  [2];
    logic [DATA_W-1:0] rd_data_s [2];

    assign wr_in_range_s = ({1'b0, writeSelect} < NUM_REGS_W);
    assign wr_is_sp_s    = (writeSelect == SP_IDX_W);
    assign wr_array_s    = writeEnable && wr_in_range_s && !wr_is_sp_s;
    assign sp_load_s     = writeEnable && wr_is_sp_s;
    assign wr_phys_s     = to_phys(writeSelect);

    stack_register_file_sp_counter #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET)
    ) u_sp_counter (
        .clk       (clk),
        .clear     (clear),
        .load      (sp_load_s),
        .load_data (dataIn),
        .inc       (spInc),
        .dec       (spDec),
        .sp        (sp_value_s),
        .overflow  (spOverflow),
        .underflow (spUnderflow)
    );

    // General-purpose register array write; clear zeroes every entry.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < PHYS_N; i++) begin
                regs_r[i] <= ALL_ZERO;
            end
        end else if (wr_array_s) begin
            regs_r[wr_phys_s] <= dataIn;
        end
    end

    assign rd_sel_s[0] = readSelectA;
    assign rd_sel_s[1] = readSelectB;

    // Read muxes: range check, then write forwarding, then SP splice, then array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = ALL_ZERO;
            if ({1'b0, rd_sel_s[p]} >= NUM_REGS_W) begin
                rd_data_s[p] = ALL_ZERO;
            end else if (BYPASS && writeEnable && (writeSelect == rd_sel_s[p])) begin
                rd_data_s[p] = dataIn;
            end else if (rd_sel_s[p] == SP_IDX_W) begin
                rd_data_s[p] = sp_value_s;
            end else begin
                rd_data_s[p] = regs_r[to_phys(rd_sel_s[p])];
            end
        end
    end

    assign dataOutA = rd_data_s[0];
    assign dataOutB = rd_data_s[1];
    assign spOut    = sp_value_s;

endmodule
